// File: rtl/cnn_pkg.sv
// cnn_pkg: shared types for the CNN datapath.
// Pooling mode, argmax history codes, pool FSM states.
package cnn_pkg;

   typedef enum logic {
      POOL_MAX = 1'b0,
      POOL_AVG = 1'b1
   } pool_mode_e;

   typedef enum logic [1:0] {
      P_IDLE = 2'd0,
      P_RUN  = 2'd1,
      P_DONE = 2'd2
   } pool_state_e;

   localparam logic [1:0] HIST_TL   = 2'b00;
   localparam logic [1:0] HIST_TR   = 2'b01;
   localparam logic [1:0] HIST_BL   = 2'b10;
   localparam logic [1:0] HIST_BR   = 2'b11;
   localparam logic [1:0] HIST_NONE = 2'b00;

   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cnn_pool_lane.sv
// cnn_pool_lane: one channel of the 2x2/stride-2 pooling stage.
// Even-row pairs park in the line buffer and are finished on the odd row.
module cnn_pool_lane
   import cnn_pkg::*;
#(
   parameter int DW   = 16,
   parameter int IN_W = 28,
   parameter int XW   = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          pix_we,
   input  logic          row_odd,
   input  logic          col_odd,
   input  logic          avg,
   input  logic [XW-1:0] idx,
   input  logic [DW-1:0] in_px,
   output logic [DW-1:0] out_px,
   output logic [1:0]    out_hist
);

   localparam int SW = DW + 2;
   localparam int LB = IN_W / 2;

   logic signed [DW-1:0] px, hold, pair_max;
   logic signed [DW-1:0] res_max, res_avg;
   logic signed [SW-1:0] px_x, hold_x, pair_x;
   logic signed [SW-1:0] pair_sum, lb_rd, sum4;
   logic signed [SW-1:0] lb_data [LB];
   logic [1:0] lb_idx [LB];
   logic [1:0] lb_hist, pair_idx, res_idx;
   logic pair_gt, win_gt;

   // strict compares keep ties on the earlier raster pixel
   always_comb begin
      px       = in_px;
      px_x     = {{2{px[DW-1]}}, px};
      hold_x   = {{2{hold[DW-1]}}, hold};
      pair_gt  = px > hold;
      pair_max = pair_gt ? px : hold;
      pair_x   = {{2{pair_max[DW-1]}}, pair_max};
      pair_idx = row_odd ? (pair_gt ? HIST_BR : HIST_BL)
                         : (pair_gt ? HIST_TR : HIST_TL);
      pair_sum = px_x + hold_x;
      lb_rd    = lb_data[idx];
      lb_hist  = lb_idx[idx];
      sum4     = lb_rd + pair_sum;
      win_gt   = pair_x > lb_rd;
      res_max  = win_gt ? pair_max : lb_rd[DW-1:0];
      res_idx  = win_gt ? pair_idx : lb_hist;
      res_avg  = DW'(sum4 >>> 2);
   end

   always_ff @(posedge clk) begin
      if (pix_we && col_odd && !row_odd) begin
         lb_data[idx] <= avg ? pair_sum : pair_x;
         lb_idx[idx]  <= avg ? HIST_NONE : pair_idx;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold     <= '0;
         out_px   <= '0;
         out_hist <= '0;
      end else if (pix_we) begin
         if (!col_odd) begin
            hold <= px;
         end else if (row_odd) begin
            out_px   <= avg ? res_avg : res_max;
            out_hist <= avg ? HIST_NONE : res_idx;
         end
      end
   end

endmodule

// File: rtl/cnn_pool_unit.sv
// cnn_pool_unit: streaming 2x2/stride-2 max/average pooling, C lanes.
// Owns raster counters, frame FSM and output addressing.
module cnn_pool_unit
   import cnn_pkg::*;
#(
   parameter int DW   = 16,
   parameter int C    = 6,
   parameter int IN_W = 28,
   parameter int IN_H = 28,
   parameter int AW   = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          mode,
   input  logic          in_valid,
   input  logic [C*DW-1:0] in_data,
   output logic          out_valid,
   output logic [C*DW-1:0] out_data,
   output logic [C*2-1:0]  out_hist,
   output logic [AW-1:0] out_addr,
   output logic          busy,
   output logic          frame_done
);

   localparam int CW = clog2_min1(IN_W);
   localparam int RW = clog2_min1(IN_H);
   localparam int XW = clog2_min1(IN_W / 2);
   localparam logic [CW-1:0] COL_LAST = CW'(IN_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IN_H - 1);
   localparam bit ODD_W = (IN_W % 2) == 1;
   localparam bit ODD_H = (IN_H % 2) == 1;

   pool_state_e state, state_nx;
   pool_mode_e mode_q, mode_cur;
   logic [CW-1:0] col, cur_col;
   logic [RW-1:0] row, cur_row;
   logic [XW-1:0] idx;
   logic [AW-1:0] wr_addr;
   logic accept, start, last, skip, use_px, fire;

   // a pixel arriving outside RUN opens a new frame at (0,0)
   always_comb begin
      accept   = in_valid && !clr;
      start    = accept && (state != P_RUN);
      cur_col  = start ? '0 : col;
      cur_row  = start ? '0 : row;
      mode_cur = start ? pool_mode_e'(mode) : mode_q;
      last     = accept && (cur_col == COL_LAST)
                 && (cur_row == ROW_LAST);
      skip     = (ODD_W && (cur_col == COL_LAST))
                 || (ODD_H && (cur_row == ROW_LAST));
      use_px   = accept && !skip;
      fire     = use_px && cur_row[0] && cur_col[0];
      idx      = XW'(cur_col >> 1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= P_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (clr)                  state_nx = P_IDLE;
      else if (last)            state_nx = P_DONE;
      else if (start)           state_nx = P_RUN;
      else if (state == P_DONE) state_nx = P_IDLE;
   end

   always_comb begin
      busy       = (state == P_RUN);
      frame_done = (state == P_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col       <= '0;
         row       <= '0;
         mode_q    <= POOL_MAX;
         wr_addr   <= '0;
         out_addr  <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         if (clr) begin
            col     <= '0;
            row     <= '0;
            wr_addr <= '0;
         end else if (accept) begin
            if (start) begin
               mode_q   <= pool_mode_e'(mode);
               wr_addr  <= '0;
               out_addr <= '0;
            end
            if (cur_col == COL_LAST) begin
               col <= '0;
               row <= (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
            end else begin
               col <= cur_col + 1'b1;
               row <= cur_row;
            end
            if (fire) begin
               out_valid <= 1'b1;
               out_addr  <= wr_addr;
               wr_addr   <= wr_addr + 1'b1;
            end
         end
      end
   end

   for (genvar k = 0; k < C; k++) begin : g_lane
      cnn_pool_lane #(
         .DW  (DW),
         .IN_W(IN_W),
         .XW  (XW)
      ) u_lane (
         .clk     (clk),
         .rst_n   (rst_n),
         .pix_we  (use_px),
         .row_odd (cur_row[0]),
         .col_odd (cur_col[0]),
         .avg     (mode_cur == POOL_AVG),
         .idx     (idx),
         .in_px   (in_data[k*DW +: DW]),
         .out_px  (out_data[k*DW +: DW]),
         .out_hist(out_hist[k*2 +: 2])
      );
   end

endmodule

// File: tb/tb_cnn_pool_unit.sv
// tb_cnn_pool_unit: directed checks of cnn_pool_unit (4x4 and 5x5 frames).
// Max, ties, average, odd size, gaps, clr, async reset.
module tb_cnn_pool_unit;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic clr = 1'b0;
   logic mode = 1'b0;
   logic in_valid = 1'b0;
   logic [31:0] in_data = '0;
   logic out_valid, busy, frame_done;
   logic [31:0] out_data;
   logic [3:0] out_hist;
   logic [15:0] out_addr;

   logic v5 = 1'b0;
   logic [31:0] d5 = '0;
   logic ov5, busy5, fd5;
   logic [31:0] od5;
   logic [3:0] oh5;
   logic [15:0] oa5;

   int checks = 0;
   int failures = 0;
   int fd_cnt = 0;

   logic signed [15:0] q0[$], q1[$], p0[$];
   logic [1:0] qh0[$], qh1[$], ph0[$];
   logic [15:0] qa[$], pa[$];

   int a0[16], a1[16];
   int e0[4], e1[4], eh0[4], eh1[4];

   always #5 clk = ~clk;

   cnn_pool_unit #(.DW(16), .C(2), .IN_W(4), .IN_H(4), .AW(16)) dut (
      .clk(clk), .rst_n(rst_n), .clr(clr), .mode(mode),
      .in_valid(in_valid), .in_data(in_data),
      .out_valid(out_valid), .out_data(out_data),
      .out_hist(out_hist), .out_addr(out_addr),
      .busy(busy), .frame_done(frame_done)
   );

   cnn_pool_unit #(.DW(16), .C(2), .IN_W(5), .IN_H(5), .AW(16)) dut5 (
      .clk(clk), .rst_n(rst_n), .clr(1'b0), .mode(1'b0),
      .in_valid(v5), .in_data(d5),
      .out_valid(ov5), .out_data(od5),
      .out_hist(oh5), .out_addr(oa5),
      .busy(busy5), .frame_done(fd5)
   );

   always @(negedge clk) begin
      if (out_valid) begin
         q0.push_back(out_data[15:0]);
         q1.push_back(out_data[31:16]);
         qh0.push_back(out_hist[1:0]);
         qh1.push_back(out_hist[3:2]);
         qa.push_back(out_addr);
      end
      if (frame_done) fd_cnt++;
      if (ov5) begin
         p0.push_back(od5[15:0]);
         ph0.push_back(oh5[1:0]);
         pa.push_back(oa5);
      end
   end

   task automatic chk(input string tag,
                      input logic signed [31:0] obs,
                      input logic signed [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic qclr();
      q0.delete(); q1.delete(); qh0.delete();
      qh1.delete(); qa.delete();
   endtask

   task automatic px(input int a, input int b);
      in_valid = 1'b1;
      in_data  = {16'(b), 16'(a)};
      step();
      in_valid = 1'b0;
   endtask

   task automatic frame(input string tag, input bit gaps,
                        input bit flip);
      qclr();
      for (int i = 0; i < 15; i++) begin
         px(a0[i], a1[i]);
         if (i == 0) chk({tag, ".busy"}, busy, 1);
         if (flip && i == 2) mode = ~mode;
         if (gaps) repeat ($urandom_range(0, 2)) step();
      end
      px(a0[15], a1[15]);
      chk({tag, ".last_ov"}, out_valid, 1);
      chk({tag, ".last_fd"}, frame_done, 1);
      step();
      chk({tag, ".fd_off"}, frame_done, 0);
      chk({tag, ".n"}, q0.size(), 4);
      for (int i = 0; i < 4 && i < q0.size(); i++) begin
         chk($sformatf("%s.d0[%0d]", tag, i), q0[i], e0[i]);
         chk($sformatf("%s.d1[%0d]", tag, i), q1[i], e1[i]);
         chk($sformatf("%s.h0[%0d]", tag, i), qh0[i], eh0[i]);
         chk($sformatf("%s.h1[%0d]", tag, i), qh1[i], eh1[i]);
         chk($sformatf("%s.a[%0d]", tag, i), qa[i], i);
      end
   endtask

   task automatic set_t1();
      for (int i = 0; i < 16; i++) begin
         a0[i] = i + 1;
         a1[i] = -(i + 1);
      end
      e0 = '{6, 8, 14, 16};
      e1 = '{-1, -3, -9, -11};
      eh0 = '{3, 3, 3, 3};
      eh1 = '{0, 0, 0, 0};
   endtask

   initial begin
      int fd0;
      #3;
      chk("rst.ov", out_valid, 0);
      chk("rst.data", out_data, 0);
      chk("rst.hist", out_hist, 0);
      chk("rst.addr", out_addr, 0);
      chk("rst.busy", busy, 0);
      chk("rst.fd", frame_done, 0);
      step();
      rst_n = 1'b1;
      step();

      // max
      mode = 1'b0;
      set_t1();
      frame("t1", 1'b0, 1'b0);

      // ties
      for (int i = 0; i < 16; i++) begin
         a0[i] = 5;
         a1[i] = 0;
      end
      a1[0] = -2; a1[1] = -2; a1[4] = -2; a1[5] = -1;
      e0 = '{5, 5, 5, 5};
      e1 = '{-1, 0, 0, 0};
      eh0 = '{0, 0, 0, 0};
      eh1 = '{3, 0, 0, 0};
      frame("t2", 1'b0, 1'b0);

      // average, mode flipped mid-frame is ignored
      for (int i = 0; i < 16; i++) begin
         a0[i] = i + 1;
         a1[i] = 0;
      end
      a1[0] = -1; a1[1] = -2; a1[4] = -2; a1[5] = -2;
      a1[2] = 7; a1[3] = 7; a1[6] = 7; a1[7] = 8;
      e0 = '{3, 5, 11, 13};
      e1 = '{-2, 7, 0, 0};
      eh0 = '{0, 0, 0, 0};
      eh1 = '{0, 0, 0, 0};
      mode = 1'b1;
      frame("t3", 1'b0, 1'b1);
      mode = 1'b0;

      // odd 5x5
      p0.delete(); ph0.delete(); pa.delete();
      for (int i = 1; i <= 25; i++) begin
         v5 = 1'b1;
         d5 = {16'd0, 16'(i)};
         step();
         v5 = 1'b0;
         if (i == 24) chk("t4.fd_early", fd5, 0);
      end
      chk("t4.fd", fd5, 1);
      chk("t4.ov_last", ov5, 0);
      step();
      chk("t4.n", p0.size(), 4);
      e0 = '{7, 9, 17, 19};
      for (int i = 0; i < 4 && i < p0.size(); i++) begin
         chk($sformatf("t4.d0[%0d]", i), p0[i], e0[i]);
         chk($sformatf("t4.h0[%0d]", i), ph0[i], 3);
         chk($sformatf("t4.a[%0d]", i), pa[i], i);
      end

      // gaps with a mode flip
      set_t1();
      frame("t5g", 1'b1, 1'b1);
      mode = 1'b0;

      // clr after pixel 7
      qclr();
      fd0 = fd_cnt;
      for (int i = 0; i < 7; i++) px(a0[i], a1[i]);
      clr = 1'b1;
      step();
      clr = 1'b0;
      repeat (3) step();
      chk("t5c.busy", busy, 0);
      chk("t5c.n", q0.size(), 1);
      chk("t5c.fd", fd_cnt, fd0);
      frame("t5c_new", 1'b0, 1'b0);

      // clr wins over a simultaneous pixel
      for (int i = 0; i < 5; i++) px(a0[i], a1[i]);
      clr = 1'b1;
      px(99, 99);
      clr = 1'b0;
      chk("t5d.busy", busy, 0);
      frame("t5d_new", 1'b0, 1'b0);

      // async reset mid-frame
      qclr();
      for (int i = 0; i < 10; i++) px(a0[i], a1[i]);
      chk("t6.pre", out_data[15:0], 8);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6.data", out_data, 0);
      chk("t6.hist", out_hist, 0);
      chk("t6.addr", out_addr, 0);
      chk("t6.busy", busy, 0);
      chk("t6.ov", out_valid, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step();
      frame("t6_new", 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
